md_issue_ctrl: RTL and testbench

MD_ISSUE_CTRL -- requirements
Module: md_issue_ctrl

---
 rtl/md_issue_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_md_issue_ctrl.sv | 428 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/md_issue_ctrl.sv
// md_issue_ctrl: issue controller between the E stage and the multiply/divide unit.
// It latches mult/multu/div/divu/mthi/mtlo requests, sends a one-cycle start
// strobe, then watches md_busy with a watchdog counter. mfhi/mflo are answered
// combinationally from the unit's HI/LO. While an operation is in flight, the
// D-stage multiply/divide-class instructions are held by stall.
module md_issue_ctrl #(
  parameter int unsigned MUL_CYC = 5,
  parameter int unsigned DIV_CYC = 10,
  parameter int unsigned SLACK   = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic [5:0]  req_funct,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  output logic        req_ready,
  input  logic        d_valid,
  input  logic        d_is_special,
  input  logic [5:0]  d_funct,
  output logic        stall,
  output logic        md_start,
  output logic [5:0]  md_funct,
  output logic [31:0] md_in1,
  output logic [31:0] md_in2,
  input  logic        md_busy,
  input  logic [31:0] md_hi,
  input  logic [31:0] md_lo,
  output logic [31:0] mf_data,
  output logic        done,
  output logic        err
);

  // Watchdog budgets. Each one is the expected busy time plus the allowed slack.
  localparam int unsigned MUL_LOAD = MUL_CYC + SLACK;
  localparam int unsigned DIV_LOAD = DIV_CYC + SLACK;
  localparam int unsigned MAX_LOAD = (MUL_LOAD > DIV_LOAD) ? MUL_LOAD : DIV_LOAD;
  localparam int unsigned CNT_W    = (MAX_LOAD < 2) ? 1 : $clog2(MAX_LOAD + 1);

  localparam logic [CNT_W-1:0] MUL_LOAD_C = CNT_W'(MUL_LOAD);
  localparam logic [CNT_W-1:0] DIV_LOAD_C = CNT_W'(DIV_LOAD);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  // SPECIAL funct codes handled here.
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MTLO  = 6'b010011;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  // Class decoders.
  function automatic logic f_is_md(input logic [5:0] f);
    return (f == F_MULT) || (f == F_MULTU) || (f == F_DIV) || (f == F_DIVU);
  endfunction

  function automatic logic f_is_mt(input logic [5:0] f);
    return (f == F_MTHI) || (f == F_MTLO);
  endfunction

  function automatic logic f_is_mf(input logic [5:0] f);
    return (f == F_MFHI) || (f == F_MFLO);
  endfunction

  function automatic logic f_is_mul(input logic [5:0] f);
    return (f == F_MULT) || (f == F_MULTU);
  endfunction

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_first;     // set only during the first WAIT cycle
  logic [5:0]       r_funct;
  logic [31:0]      r_a;
  logic [31:0]      r_b;
  logic             r_md_start;
  logic             r_err;

  logic             w_req_md;
  logic             w_req_mt;
  logic             w_req_mf;
  logic             w_d_class;
  logic             w_busy_path;
  logic [31:0]      w_mf_data;

  assign w_req_md  = req_valid & f_is_md(req_funct);
  assign w_req_mt  = req_valid & f_is_mt(req_funct);
  assign w_req_mf  = req_valid & f_is_mf(req_funct);
  assign w_d_class = d_valid & d_is_special &
                     (f_is_md(d_funct) | f_is_mt(d_funct) | f_is_mf(d_funct));

  // The HI/LO path is busy when an operation is in flight, or when one is
  // being accepted this cycle.
  assign w_busy_path = (r_state != S_IDLE) | w_req_md | w_req_mt;

  // Move-from answers straight from the unit's HI/LO; zero when no mf request is present.
  always_comb begin
    // NOTE: assign a default before any condition, so that no path leaves
    // w_mf_data unassigned and no latch is inferred.
    w_mf_data = '0;
    if (w_req_mf) begin
      w_mf_data = (req_funct == F_MFHI) ? md_hi : md_lo;
    end
  end

  // Issue FSM: accept, one-cycle start strobe, then the watched wait for md_busy.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: every control and datapath register resets asynchronously, so the
    // outputs are clean while reset is low, even without a clock. Sequential
    // state uses non-blocking assignments only.
    if (!reset) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_first    <= 1'b0;
      r_funct    <= '0;
      r_a        <= '0;
      r_b        <= '0;
      r_md_start <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_md_start <= 1'b0;
      case (r_state)
        S_IDLE: begin
          // Move-from and unknown functs are accepted here with no state change.
          if (w_req_md | w_req_mt) begin
            r_funct    <= req_funct;
            r_a        <= req_a;
            r_b        <= req_b;
            r_md_start <= 1'b1;
            r_state    <= S_ISSUE;
          end
        end

        S_ISSUE: begin
          if (f_is_md(r_funct)) begin
            r_cnt   <= f_is_mul(r_funct) ? MUL_LOAD_C : DIV_LOAD_C;
            r_first <= 1'b1;
            r_state <= S_WAIT;
          end else begin
            // mthi/mtlo complete in the unit with the start strobe.
            r_state <= S_IDLE;
          end
        end

        S_WAIT: begin
          r_cnt   <= r_cnt - CNT_ONE;
          r_first <= 1'b0;
          if (!md_busy) begin
            // A unit that never reported busy did not take the start.
            if (r_first) begin
              r_err <= 1'b1;
            end
            r_cnt   <= '0;
            r_state <= S_IDLE;
          end else if (r_cnt <= CNT_ONE) begin
            // The budget is used up while the unit is still busy.
            r_err   <= 1'b1;
            r_cnt   <= '0;
            r_state <= S_IDLE;
          end
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign req_ready = (r_state == S_IDLE);
  assign md_start  = r_md_start;
  assign md_funct  = r_funct;
  assign md_in1    = r_a;
  assign md_in2    = r_b;
  assign err       = r_err;
  assign mf_data   = w_mf_data;
  assign stall     = w_d_class & w_busy_path;

  // done marks the last WAIT cycle. The first WAIT cycle is excluded, because
  // a drop of md_busy there is reported as an error.
  assign done = (r_state == S_WAIT) & ~r_first & ~md_busy;

endmodule

// File: tb/tb_md_issue_ctrl.sv
// Testbench for md_issue_ctrl. It contains a simple multiply/divide unit model
// with a programmable busy length, table vectors for the accept-cycle decode,
// directed multi-cycle sequences, and a randomized run checked against a
// timeline model of the controller.
module tb_md_issue_ctrl;

  localparam int MUL_CYC = 5;
  localparam int DIV_CYC = 10;
  localparam int SLACK   = 2;

  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MTLO  = 6'b010011;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] F_ADDU  = 6'b100001;
  localparam logic [5:0] F_BAD   = 6'b111111;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic [5:0]  req_funct;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic        req_ready;
  logic        d_valid;
  logic        d_is_special;
  logic [5:0]  d_funct;
  logic        stall;
  logic        md_start;
  logic [5:0]  md_funct;
  logic [31:0] md_in1;
  logic [31:0] md_in2;
  logic        md_busy;
  logic [31:0] md_hi;
  logic [31:0] md_lo;
  logic [31:0] mf_data;
  logic        done;
  logic        err;

  int n_vec = 0;
  int n_err = 0;

  md_issue_ctrl #(.MUL_CYC(MUL_CYC), .DIV_CYC(DIV_CYC), .SLACK(SLACK)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_funct(req_funct), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready),
    .d_valid(d_valid), .d_is_special(d_is_special), .d_funct(d_funct),
    .stall(stall),
    .md_start(md_start), .md_funct(md_funct), .md_in1(md_in1), .md_in2(md_in2),
    .md_busy(md_busy), .md_hi(md_hi), .md_lo(md_lo),
    .mf_data(mf_data), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  function automatic logic f_md(input logic [5:0] f);
    return f inside {F_MULT, F_MULTU, F_DIV, F_DIVU};
  endfunction
  function automatic logic f_mt(input logic [5:0] f);
    return f inside {F_MTHI, F_MTLO};
  endfunction
  function automatic logic f_mf(input logic [5:0] f);
    return f inside {F_MFHI, F_MFLO};
  endfunction

  // Unit model: the arithmetic result as {HI, LO}.
  function automatic logic [63:0] unit_calc(input logic [5:0] f, input logic [31:0] a,
                                            input logic [31:0] b);
    logic signed [63:0] sp;
    logic [63:0] r;
    r = '0;
    case (f)
      F_MULT: begin
        sp = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        r  = sp;
      end
      F_MULTU: r = {32'b0, a} * {32'b0, b};
      F_DIV:   if (b != 0) r = {32'($signed(a) % $signed(b)), 32'($signed(a) / $signed(b))};
      F_DIVU:  if (b != 0) r = {a % b, a / b};
      default: r = '0;
    endcase
    return r;
  endfunction

  // The unit model stays busy for cfg_busy_len cycles after each start strobe.
  int          cfg_busy_len = 0;
  int          u_busy_cnt   = 0;
  logic [31:0] u_hi   = '0;
  logic [31:0] u_lo   = '0;
  logic [63:0] u_pend = '0;

  always @(posedge clk) begin
    if (md_start) begin
      if (f_md(md_funct)) begin
        if (cfg_busy_len == 0) {u_hi, u_lo} <= unit_calc(md_funct, md_in1, md_in2);
        else u_pend <= unit_calc(md_funct, md_in1, md_in2);
        u_busy_cnt <= cfg_busy_len;
      end else if (md_funct == F_MTHI) begin
        u_hi <= md_in1;
      end else if (md_funct == F_MTLO) begin
        u_lo <= md_in1;
      end
    end else if (u_busy_cnt != 0) begin
      u_busy_cnt <= u_busy_cnt - 1;
      if (u_busy_cnt == 1) {u_hi, u_lo} <= u_pend;
    end
  end

  assign md_busy = (u_busy_cnt != 0);
  assign md_hi   = u_hi;
  assign md_lo   = u_lo;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive inputs 1 ns after the rising edge and sample at the falling edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    #4;
  endtask

  task automatic idle_inputs();
    req_valid = 1'b0; req_funct = '0; req_a = '0; req_b = '0;
    d_valid = 1'b0; d_is_special = 1'b0; d_funct = '0;
  endtask

  // Advance until the controller is idle and the unit model is quiet (bounded).
  task automatic wait_quiet();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (!ok) begin
        tick();
        if (req_ready && !md_busy) ok = 1'b1;
      end
    end
    check("wait_quiet", 32'(ok), 32'd1);
  endtask

  task automatic send_mt(input logic [5:0] f, input logic [31:0] a);
    wait_quiet();
    req_valid = 1'b1; req_funct = f; req_a = a; req_b = '0;
    tick();
    idle_inputs();
  endtask

  function automatic logic [5:0] pick_funct(input int s);
    case (s)
      0: return F_MULT;  1: return F_MULTU; 2: return F_DIV;  3: return F_DIVU;
      4: return F_MTHI;  5: return F_MTLO;  6: return F_MFHI; 7: return F_MFLO;
      8: return F_ADDU;  9: return F_BAD;
      default: return 6'($urandom);
    endcase
  endfunction

  typedef struct {
    logic        rv;
    logic [5:0]  rf;
    logic        dv;
    logic        ds;
    logic [5:0]  df;
    logic        exp_stall;
    logic [31:0] exp_mf;
    logic        exp_start;
  } vec_t;

  vec_t vt[10];

  // Timeline model state used by the randomized run.
  int          m_idle_from, m_issue_cyc, m_done_cyc, m_err_from;
  logic [5:0]  m_funct;
  logic [31:0] m_a, m_b;

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    // Table vectors. They start in IDLE with HI=CAFE0001 and LO=0BAD0002.
    vt[0] = '{1'b1, F_MFHI, 1'b1, 1'b1, F_MFLO, 1'b0, 32'hCAFE0001, 1'b0};
    vt[1] = '{1'b1, F_MFLO, 1'b1, 1'b1, F_MULT, 1'b0, 32'h0BAD0002, 1'b0};
    vt[2] = '{1'b0, F_MFHI, 1'b1, 1'b1, F_MFHI, 1'b0, 32'h0,        1'b0};
    vt[3] = '{1'b1, F_BAD,  1'b1, 1'b1, F_MFHI, 1'b0, 32'h0,        1'b0};
    vt[4] = '{1'b1, F_ADDU, 1'b1, 1'b0, F_MULT, 1'b0, 32'h0,        1'b0};
    vt[5] = '{1'b1, F_MFHI, 1'b0, 1'b1, F_DIV,  1'b0, 32'hCAFE0001, 1'b0};
    vt[6] = '{1'b1, F_MULT, 1'b1, 1'b1, F_MFHI, 1'b1, 32'h0,        1'b1};
    vt[7] = '{1'b1, F_MTLO, 1'b1, 1'b1, F_ADDU, 1'b0, 32'h0,        1'b1};
    vt[8] = '{1'b1, F_DIV,  1'b0, 1'b1, F_MFLO, 1'b0, 32'h0,        1'b1};
    vt[9] = '{1'b1, F_DIVU, 1'b1, 1'b1, F_MTLO, 1'b1, 32'h0,        1'b1};

    idle_inputs();
    reset = 1'b0;
    #3;
    check("rst md_start", 32'(md_start), 0);
    check("rst done", 32'(done), 0);
    check("rst err", 32'(err), 0);
    check("rst md_funct", 32'(md_funct), 0);
    check("rst md_in1", md_in1, 0);
    check("rst md_in2", md_in2, 0);
    check("rst req_ready", 32'(req_ready), 1);
    tick(); tick();
    reset = 1'b1;

    // Table run at the accept cycle.
    send_mt(F_MTHI, 32'hCAFE0001);
    send_mt(F_MTLO, 32'h0BAD0002);
    for (int i = 0; i < 10; i++) begin
      wait_quiet();
      cfg_busy_len = 3;
      req_valid = vt[i].rv; req_funct = vt[i].rf; req_a = '0; req_b = '0;
      d_valid = vt[i].dv; d_is_special = vt[i].ds; d_funct = vt[i].df;
      sample();
      check($sformatf("tbl%0d ready", i), 32'(req_ready), 1);
      check($sformatf("tbl%0d stall", i), 32'(stall), 32'(vt[i].exp_stall));
      check($sformatf("tbl%0d mf_data", i), mf_data, vt[i].exp_mf);
      tick();
      idle_inputs();
      sample();
      check($sformatf("tbl%0d md_start", i), 32'(md_start), 32'(vt[i].exp_start));
    end

    // mult FFFFFFFE * 3 with 5 busy cycles.
    wait_quiet();
    cfg_busy_len = 5;
    req_valid = 1'b1; req_funct = F_MULT; req_a = 32'hFFFFFFFE; req_b = 32'd3;
    sample();
    check("mult ready", 32'(req_ready), 1);
    tick(); idle_inputs(); sample();
    check("mult md_start", 32'(md_start), 1);
    check("mult md_funct", 32'(md_funct), 32'(F_MULT));
    check("mult md_in1", md_in1, 32'hFFFFFFFE);
    check("mult md_in2", md_in2, 32'd3);
    for (int k = 1; k <= 6; k++) begin
      tick(); sample();
      if (k == 1) check("mult start one cycle", 32'(md_start), 0);
      check($sformatf("mult done w%0d", k), 32'(done), 32'(k == 6));
    end
    tick(); sample();
    check("mult idle done", 32'(done), 0);
    check("mult idle ready", 32'(req_ready), 1);
    check("mult err", 32'(err), 0);
    req_valid = 1'b1; req_funct = F_MFHI; sample();
    check("mult mfhi", mf_data, 32'hFFFFFFFF);
    tick(); req_funct = F_MFLO; sample();
    check("mult mflo", mf_data, 32'hFFFFFFFA);
    tick(); idle_inputs();

    // divu 100 / 7 with a D-stage mflo held for the whole operation.
    wait_quiet();
    cfg_busy_len = 10;
    req_valid = 1'b1; req_funct = F_DIVU; req_a = 32'd100; req_b = 32'd7;
    d_valid = 1'b1; d_is_special = 1'b1; d_funct = F_MFLO;
    sample();
    check("divu stall accept", 32'(stall), 1);
    tick(); req_valid = 1'b0; sample();
    check("divu stall issue", 32'(stall), 1);
    for (int k = 1; k <= 11; k++) begin
      tick(); sample();
      check($sformatf("divu stall w%0d", k), 32'(stall), 1);
      check($sformatf("divu done w%0d", k), 32'(done), 32'(k == 11));
    end
    tick(); sample();
    check("divu stall released", 32'(stall), 0);
    idle_inputs();
    req_valid = 1'b1; req_funct = F_MFLO; sample();
    check("divu mflo", mf_data, 32'd14);
    tick(); req_funct = F_MFHI; sample();
    check("divu mfhi", mf_data, 32'd2);
    tick(); idle_inputs();

    // mthi 0x1234: ISSUE, then straight back to IDLE.
    wait_quiet();
    req_valid = 1'b1; req_funct = F_MTHI; req_a = 32'h1234; req_b = '0;
    d_valid = 1'b1; d_is_special = 1'b1; d_funct = F_MFLO;
    sample();
    check("mthi stall accept", 32'(stall), 1);
    tick(); req_valid = 1'b0; sample();
    check("mthi md_start", 32'(md_start), 1);
    check("mthi stall issue", 32'(stall), 1);
    check("mthi done issue", 32'(done), 0);
    tick(); sample();
    check("mthi ready", 32'(req_ready), 1);
    check("mthi stall after", 32'(stall), 0);
    check("mthi done after", 32'(done), 0);
    idle_inputs();
    req_valid = 1'b1; req_funct = F_MFHI; sample();
    check("mthi mfhi", mf_data, 32'h1234);
    tick(); idle_inputs();

    // Watchdog: the unit stays busy for 15 cycles after a mult.
    wait_quiet();
    cfg_busy_len = 15;
    req_valid = 1'b1; req_funct = F_MULT; req_a = 32'd2; req_b = 32'd3;
    tick(); idle_inputs();
    for (int k = 1; k <= 7; k++) begin
      tick(); sample();
      check($sformatf("wd err w%0d", k), 32'(err), 0);
      check($sformatf("wd ready w%0d", k), 32'(req_ready), 0);
      check($sformatf("wd done w%0d", k), 32'(done), 0);
    end
    tick(); sample();
    check("wd err set", 32'(err), 1);
    check("wd idle", 32'(req_ready), 1);
    check("wd no done", 32'(done), 0);
    for (int k = 0; k < 10; k++) tick();
    sample();
    check("wd err sticky", 32'(err), 1);

    // Reset asserted in WAIT cycle 3 of a div, then a clean mult with a D-stage addu.
    wait_quiet();
    cfg_busy_len = 10;
    req_valid = 1'b1; req_funct = F_DIV; req_a = 32'd50; req_b = 32'd5;
    d_valid = 1'b1; d_is_special = 1'b1; d_funct = F_MFLO;
    tick(); req_valid = 1'b0;
    tick(); tick(); tick();
    reset = 1'b0;
    #1;
    check("mid rst md_start", 32'(md_start), 0);
    check("mid rst done", 32'(done), 0);
    check("mid rst err", 32'(err), 0);
    check("mid rst md_funct", 32'(md_funct), 0);
    check("mid rst md_in1", md_in1, 0);
    check("mid rst md_in2", md_in2, 0);
    check("mid rst stall", 32'(stall), 0);
    check("mid rst ready", 32'(req_ready), 1);
    tick(); tick();
    reset = 1'b1;
    cfg_busy_len = 5;
    req_valid = 1'b1; req_funct = F_MULT; req_a = 32'd7; req_b = 32'd6;
    d_valid = 1'b1; d_is_special = 1'b1; d_funct = F_ADDU;
    sample();
    check("post rst ready", 32'(req_ready), 1);
    check("addu stall accept", 32'(stall), 0);
    tick(); req_valid = 1'b0; sample();
    check("post rst md_start", 32'(md_start), 1);
    for (int k = 1; k <= 6; k++) begin
      tick(); sample();
      if (k == 1) check("post rst start one cycle", 32'(md_start), 0);
      check($sformatf("addu stall w%0d", k), 32'(stall), 0);
      check($sformatf("post rst done w%0d", k), 32'(done), 32'(k == 6));
    end
    tick(); idle_inputs();
    req_valid = 1'b1; req_funct = F_MFLO; sample();
    check("post rst mflo", mf_data, 32'd42);
    tick(); req_funct = F_MFHI; sample();
    check("post rst mfhi", mf_data, 32'd0);
    tick(); idle_inputs();

    // Randomized run against the timeline model.
    wait_quiet();
    m_idle_from = 0; m_issue_cyc = -1; m_done_cyc = -1; m_err_from = 1 << 30;
    m_funct = F_MULT; m_a = 32'd7; m_b = 32'd6;
    for (int c = 0; c < 600; c++) begin
      logic        exp_idle;
      logic        exp_stall;
      logic [31:0] exp_mf;
      req_valid    = 1'($urandom_range(0, 1));
      req_funct    = pick_funct($urandom_range(0, 10));
      req_a        = $urandom;
      req_b        = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      d_valid      = 1'($urandom_range(0, 1));
      d_is_special = ($urandom_range(0, 3) != 0);
      d_funct      = pick_funct($urandom_range(0, 10));
      cfg_busy_len = $urandom_range(0, 14);
      sample();

      exp_idle  = (c >= m_idle_from);
      exp_stall = d_valid && d_is_special && (f_md(d_funct) || f_mt(d_funct) || f_mf(d_funct)) &&
                  (!exp_idle || (req_valid && (f_md(req_funct) || f_mt(req_funct))));
      exp_mf    = (req_valid && f_mf(req_funct)) ? ((req_funct == F_MFHI) ? md_hi : md_lo) : 32'd0;
      check($sformatf("rnd%0d ready", c), 32'(req_ready), 32'(exp_idle));
      check($sformatf("rnd%0d md_start", c), 32'(md_start), 32'(c == m_issue_cyc));
      check($sformatf("rnd%0d done", c), 32'(done), 32'(c == m_done_cyc));
      check($sformatf("rnd%0d err", c), 32'(err), 32'(c >= m_err_from));
      check($sformatf("rnd%0d stall", c), 32'(stall), 32'(exp_stall));
      check($sformatf("rnd%0d mf_data", c), mf_data, exp_mf);
      check($sformatf("rnd%0d md_funct", c), 32'(md_funct), 32'(m_funct));
      check($sformatf("rnd%0d md_in1", c), md_in1, m_a);
      check($sformatf("rnd%0d md_in2", c), md_in2, m_b);

      // At the issue cycle, the busy length the unit will use fixes the outcome.
      if (c == m_issue_cyc && f_md(m_funct)) begin
        int load;
        int len;
        load = (m_funct == F_MULT || m_funct == F_MULTU) ? MUL_CYC + SLACK : DIV_CYC + SLACK;
        len  = cfg_busy_len;
        if (len == 0) begin
          if (c + 2 < m_err_from) m_err_from = c + 2;
          m_idle_from = c + 2;
        end else if (len < load) begin
          m_done_cyc  = c + 1 + len;
          m_idle_from = c + 2 + len;
        end else begin
          if (c + 1 + load < m_err_from) m_err_from = c + 1 + load;
          m_idle_from = c + 1 + load;
        end
      end
      if (exp_idle && req_valid && (f_md(req_funct) || f_mt(req_funct))) begin
        m_funct     = req_funct;
        m_a         = req_a;
        m_b         = req_b;
        m_issue_cyc = c + 1;
        m_idle_from = f_mt(req_funct) ? c + 2 : c + 100000;
      end
      tick();
    end
    idle_inputs();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
